trng_sampler: RTL and testbench

TRNG_SAMPLER -- requirements
Module: trng_sampler

---
 rtl/trng_pkg.sv | 15 +
 rtl/trng_sync.sv | 22 ++
 rtl/trng_sampler.sv | 150 +++++++++++++++
 tb/tb_trng_sampler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types and constants for the TRNG sampler
package trng_pkg;

    localparam int OUT_WIDTH     = 32;
    localparam int RCT_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RELEASE,
        HOLD,
        FAIL
    } trng_state_t;

endpackage

// File: rtl/trng_sync.sv
// rtl/trng_sync.sv - two-flop synchronizer for a single asynchronous bit
module trng_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trng_sampler.sv
// rtl/trng_sampler.sv - TRNG handshake, sample packer and repetition-count health test
module trng_sampler
    import trng_pkg::*;
#(
    parameter int TRNG_WIDTH = 4,
    parameter int RCT_CUTOFF = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  trng_req,
    input  logic [TRNG_WIDTH-1:0] trng_word,
    input  logic                  trng_valid,
    output logic [OUT_WIDTH-1:0]  rand_word,
    output logic                  rand_valid,
    input  logic                  rand_ready,
    output logic                  health_fail
);

    localparam int N  = OUT_WIDTH / TRNG_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] FULL = CW'(N);
    localparam logic [RCT_CNT_WIDTH-1:0] CUTOFF  = RCT_CNT_WIDTH'(RCT_CUTOFF);
    localparam logic [RCT_CNT_WIDTH-1:0] RUN_MAX = '1;
    localparam logic [RCT_CNT_WIDTH-1:0] RUN_ONE = RCT_CNT_WIDTH'(1);

    trng_state_t              state;
    trng_state_t              state_next;
    logic                     vsync;
    logic [1:0]               settle_cnt;
    logic                     settle_done;
    logic [OUT_WIDTH-1:0]     pack_reg;
    logic [OUT_WIDTH-1:0]     pack_next;
    logic [CW-1:0]            pack_cnt;
    logic [TRNG_WIDTH-1:0]    prev_sample;
    logic [RCT_CNT_WIDTH-1:0] run_cnt;
    logic [RCT_CNT_WIDTH-1:0] run_next;
    logic                     capture;
    logic                     fill_now;
    logic                     fail_now;
    logic                     pack_full;
    logic                     out_free;
    logic                     xfer;
    logic                     move;
    logic [OUT_WIDTH-1:0]     move_word;

    trng_sync u_valid_sync (
        .clk   (clk),
        .reset (reset),
        .d     (trng_valid),
        .q     (vsync)
    );

    assign settle_done = (settle_cnt == 2'd2);
    assign capture     = (state == REQ) && vsync;
    assign fill_now    = capture && (pack_cnt == LAST);
    assign fail_now    = capture && (run_next >= CUTOFF);
    assign pack_full   = (pack_cnt == FULL);
    assign xfer        = rand_valid && rand_ready;
    assign out_free    = !rand_valid || rand_ready;
    // A completed word leaves the packer whenever the output slot is free or drains this edge.
    assign move        = !fail_now && out_free && (fill_now || pack_full);
    assign move_word   = fill_now ? pack_next : pack_reg;

    // Packer contents with the incoming sample dropped into the next free slot.
    always_comb begin
        pack_next = pack_reg;
        for (int k = 0; k < N; k++) begin
            if (pack_cnt == CW'(k)) begin
                pack_next[k*TRNG_WIDTH +: TRNG_WIDTH] = trng_word;
            end
        end
    end

    // Run length including the sample being captured; first sample after reset starts at 1.
    always_comb begin
        run_next = RUN_ONE;
        if (run_cnt != '0 && trng_word == prev_sample) begin
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_ONE;
        end
    end

    // Handshake sequencing; IDLE waits for the synchronizer to refill after reset.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (settle_done && !vsync) state_next = REQ;
            REQ:     if (capture) state_next = fail_now ? FAIL : RELEASE;
            RELEASE: if (!vsync) state_next = (pack_full && !move) ? HOLD : REQ;
            HOLD:    if (move) state_next = REQ;
            FAIL:    state_next = FAIL;
            default: state_next = IDLE;
        endcase
    end

    // State register; trng_req is registered from the next state so it is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            trng_req   <= 1'b0;
            settle_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            trng_req <= (state_next == REQ);
            if (!settle_done) settle_cnt <= settle_cnt + 2'd1;
        end
    end

    // Packer fill/flush and the repetition-count tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack_reg    <= '0;
            pack_cnt    <= '0;
            prev_sample <= '0;
            run_cnt     <= '0;
            health_fail <= 1'b0;
        end else begin
            if (capture) begin
                prev_sample <= trng_word;
                run_cnt     <= run_next;
            end
            if (fail_now) begin
                health_fail <= 1'b1;
                pack_reg    <= '0;
                pack_cnt    <= '0;
            end else if (move) begin
                pack_cnt <= '0;
            end else if (capture) begin
                pack_reg <= pack_next;
                pack_cnt <= pack_cnt + CW'(1);
            end
        end
    end

    // Output register: a failure withdraws any presented word and keeps it withdrawn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rand_word  <= '0;
            rand_valid <= 1'b0;
        end else if (fail_now || state == FAIL) begin
            rand_valid <= 1'b0;
        end else if (move) begin
            rand_word  <= move_word;
            rand_valid <= 1'b1;
        end else if (xfer) begin
            rand_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_sampler.sv
// tb/tb_trng_sampler.sv - scoreboard testbench for trng_sampler
module tb_trng_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        trng_req;
    logic [3:0]  trng_word;
    logic        trng_valid;
    logic [31:0] rand_word;
    logic        rand_valid;
    logic        rand_ready;
    logic        health_fail;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    logic [3:0]  sample_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc    = '0;
    int          acc_n  = 0;
    bit          pulse_mode = 1'b0;
    bit          hold_ack   = 1'b0;
    logic [31:0] sb_exp;

    trng_sampler #(.TRNG_WIDTH(4), .RCT_CUTOFF(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .trng_req    (trng_req),
        .trng_word   (trng_word),
        .trng_valid  (trng_valid),
        .rand_word   (rand_word),
        .rand_valid  (rand_valid),
        .rand_ready  (rand_ready),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    // TRNG model: four-phase responder with random asynchronous delays.
    initial begin
        trng_valid = 1'b0;
        trng_word  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (trng_req === 1'b1 && sample_q.size() != 0 && reset === 1'b0) begin
                #($urandom_range(0, 5));
                if (trng_req === 1'b1 && sample_q.size() != 0) begin
                    trng_word  = sample_q.pop_front();
                    trng_valid = 1'b1;
                    if (pulse_mode) begin
                        #10;
                        trng_valid = 1'b0;
                        wait (trng_req === 1'b0);
                    end else begin
                        wait (trng_req === 1'b0);
                        if (hold_ack) wait (!hold_ack);
                        else #($urandom_range(1, 6));
                        trng_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard: every transfer is popped against the queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && rand_valid === 1'b1 && rand_ready === 1'b1) begin
            n_cmp++;
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_extra: got rand_word=%h, expected no transfer", rand_word);
            end else begin
                sb_exp = exp_q.pop_front();
                if (rand_word !== sb_exp) begin
                    n_fail++;
                    $display("FAIL scoreboard_word: got %h, expected %h", rand_word, sb_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic feed(input logic [3:0] s);
        sample_q.push_back(s);
        acc = acc | ({28'd0, s} << (4 * acc_n));
        acc_n++;
        if (acc_n == 8) begin
            exp_q.push_back(acc);
            acc   = '0;
            acc_n = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        reset      = 1'b1;
        sample_q.delete();
        exp_q.delete();
        acc        = '0;
        acc_n      = 0;
        pulse_mode = 1'b0;
        hold_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && sample_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 4;
        if (trng_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %b, expected 0", trng_req); end
        if (rand_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rand_valid); end
        if (rand_word !== 32'h0)  begin n_fail++; $display("FAIL reset_word: got %h, expected 0", rand_word); end
        if (health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health: got %b, expected 0", health_fail); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        bit seen = 1'b0;
        rand_ready = 1'b1;
        for (int k = 1; k <= 8; k++) sample_q.push_back(4'(k));
        exp_q.push_back(32'h87654321);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rand_valid === 1'b1) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen || rand_word !== 32'h87654321) begin
            n_fail++;
            $display("FAIL basic_word: got valid=%b word=%h, expected 87654321", seen, rand_word);
        end
        wait_drain(1000, ok);
        n_cmp += 2;
        if (!ok) begin n_fail++; $display("FAIL basic_drain: got %0d words pending, expected 0", exp_q.size()); end
        if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b, expected 0", rand_valid); end
    endtask

    task automatic test_hold_stall();
        logic [31:0] w1, w2;
        bit req_seen = 1'b0;
        rand_ready = 1'b0;
        for (int k = 0; k < 16; k++) feed(4'((5 * k + 3) & 15));
        w1 = exp_q[0];
        w2 = exp_q[1];
        for (int i = 0; i < 2000 && sample_q.size() != 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_cmp += 2;
        if (rand_valid !== 1'b1 || rand_word !== w1) begin
            n_fail++; $display("FAIL hold_first: got valid=%b word=%h, expected 1 %h", rand_valid, rand_word, w1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trng_req !== 1'b0) req_seen = 1'b1;
        end
        if (req_seen) begin n_fail++; $display("FAIL hold_req: got trng_req=1 while stalled, expected 0"); end
        n_cmp++;
        if (rand_word !== w1) begin n_fail++; $display("FAIL hold_stable: got %h, expected %h", rand_word, w1); end
        @(posedge clk);
        #1;
        rand_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rand_valid !== 1'b1 || rand_word !== w1) begin
            n_fail++; $display("FAIL hold_release1: got valid=%b word=%h, expected 1 %h", rand_valid, rand_word, w1);
        end
        @(negedge clk);
        n_cmp++;
        if (rand_valid !== 1'b1 || rand_word !== w2) begin
            n_fail++; $display("FAIL hold_no_bubble: got valid=%b word=%h, expected 1 %h", rand_valid, rand_word, w2);
        end
        @(negedge clk);
        n_cmp++;
        if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL hold_empty: got valid=%b, expected 0", rand_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] s, prev;
        bit ok = 1'b0;
        prev = 4'hF;
        for (int k = 0; k < 24; k++) begin
            s = 4'($urandom_range(0, 15));
            if (s == prev) s = s + 4'd1;
            feed(s);
            prev = s;
        end
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rand_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && sample_q.size() == 0) begin ok = 1'b1; break; end
        end
        rand_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d words pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_rct_pass();
        bit ok;
        int x0;
        do_reset();
        rand_ready = 1'b1;
        x0 = n_xfer;
        for (int k = 0; k < 15; k++) feed(4'hA);
        feed(4'hB);
        for (int k = 0; k < 15; k++) feed(4'hA);
        feed(4'hC);
        wait_drain(4000, ok);
        n_cmp += 3;
        if (!ok) begin n_fail++; $display("FAIL rct_pass_drain: got %0d words pending, expected 0", exp_q.size()); end
        if (health_fail !== 1'b0) begin n_fail++; $display("FAIL rct_pass_health: got %b, expected 0", health_fail); end
        if (n_xfer - x0 != 4) begin n_fail++; $display("FAIL rct_pass_count: got %0d words, expected 4", n_xfer - x0); end
    endtask

    task automatic test_rct_fail(input bit ready);
        bit seen_fail = 1'b0;
        bit saw_valid = 1'b0;
        bit req_seen  = 1'b0;
        do_reset();
        rand_ready = ready;
        for (int k = 0; k < 16; k++) sample_q.push_back(4'hA);
        if (ready) exp_q.push_back(32'hAAAAAAAA);
        for (int k = 0; k < 4; k++) sample_q.push_back(4'h5);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rand_valid === 1'b1) saw_valid = 1'b1;
            if (health_fail === 1'b1) begin seen_fail = 1'b1; break; end
        end
        n_cmp += 4;
        if (!seen_fail) begin n_fail++; $display("FAIL rct_fail_flag(r=%0d): got health_fail=0, expected 1", ready); end
        if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL rct_fail_valid(r=%0d): got %b, expected 0", ready, rand_valid); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rct_fail_words(r=%0d): got %0d pending, expected 0", ready, exp_q.size()); end
        if (!saw_valid) begin n_fail++; $display("FAIL rct_fail_presented(r=%0d): got no word, expected one", ready); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (trng_req !== 1'b0 || rand_valid !== 1'b0) req_seen = 1'b1;
        end
        n_cmp += 3;
        if (req_seen) begin n_fail++; $display("FAIL rct_fail_absorb(r=%0d): got req/valid high in FAIL, expected 0", ready); end
        if (sample_q.size() != 4) begin n_fail++; $display("FAIL rct_fail_consumed(r=%0d): got %0d left, expected 4", ready, sample_q.size()); end
        if (health_fail !== 1'b1) begin n_fail++; $display("FAIL rct_fail_sticky(r=%0d): got %b, expected 1", ready, health_fail); end
    endtask

    task automatic test_reset_mid_handshake();
        bit seen = 1'b0;
        bit req_seen = 1'b0;
        do_reset();
        hold_ack = 1'b1;
        sample_q.push_back(4'h3);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (trng_valid === 1'b1) begin seen = 1'b1; break; end
        end
        #1;
        n_cmp++;
        if (!seen || trng_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got ack=%b req=%b, expected 1 1", seen, trng_req); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (trng_req !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got trng_req=%b, expected 0", trng_req); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (trng_req !== 1'b0) req_seen = 1'b1;
        end
        n_cmp++;
        if (req_seen) begin n_fail++; $display("FAIL midrst_ack_high: got trng_req=1 while ack high, expected 0"); end
        #2;
        hold_ack = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (trng_req !== 1'b0) begin n_fail++; $display("FAIL midrst_low1: got %b, expected 0", trng_req); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (trng_req !== 1'b0) begin n_fail++; $display("FAIL midrst_low2: got %b, expected 0", trng_req); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (trng_req !== 1'b1) begin n_fail++; $display("FAIL midrst_rise: got %b, expected 1", trng_req); end
    endtask

    task automatic test_pulse_ack();
        bit ok;
        int x0;
        do_reset();
        pulse_mode = 1'b1;
        rand_ready = 1'b1;
        x0 = n_xfer;
        for (int k = 0; k < 16; k++) feed(4'((3 * k + 1) & 15));
        wait_drain(4000, ok);
        repeat (20) @(negedge clk);
        n_cmp += 3;
        if (!ok) begin n_fail++; $display("FAIL pulse_drain: got %0d words pending, expected 0", exp_q.size()); end
        if (n_xfer - x0 != 2) begin n_fail++; $display("FAIL pulse_count: got %0d words, expected 2", n_xfer - x0); end
        if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_idle: got valid=%b, expected 0", rand_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_back_to_back();
        test_rct_pass();
        test_rct_fail(1'b1);
        test_rct_fail(1'b0);
        test_reset_mid_handshake();
        test_pulse_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
